// File: rtl/pixel_pack_unit.sv
// Packs the 4-lane thresholded PE result stream into 32-bit frame words, LSB first,
// and counts foreground pixels. One pixel group is read per cycle from a synchronous RAM.
module pixel_pack_unit #(
    parameter int NUM_PIXELS = 1024,
    parameter int RD_ADDR_W  = 8,
    parameter int WR_ADDR_W  = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          pack_start,
    output logic [RD_ADDR_W-1:0]          pe_rd_addr,
    input  logic [3:0]                    pe_rd_data,
    output logic                          out_wr_en,
    output logic [WR_ADDR_W-1:0]          out_wr_addr,
    output logic [31:0]                   out_wr_data,
    output logic [$clog2(NUM_PIXELS):0]   fg_count,
    output logic                          pack_done,
    output logic                          busy
);

    localparam int CNT_W = $clog2(NUM_PIXELS) + 1;
    localparam logic [RD_ADDR_W-1:0] LAST_ADDR = RD_ADDR_W'(NUM_PIXELS / 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   armed;
    logic                   rd_valid;
    logic [2:0]             nib_idx;
    logic [WR_ADDR_W-1:0]   word_idx;
    logic [27:0]            acc;
    logic                   start;
    logic                   capture;
    logic [2:0]             nib_ones;

    // A frame only starts once pack_start has been seen low since the previous start.
    assign start    = (state == IDLE) && pack_start && armed;
    // rd_valid marks the cycle the RAM returns data for an address issued in READ.
    assign capture  = rd_valid && pack_start && ((state == READ) || (state == DRAIN));
    assign nib_ones = 3'(pe_rd_data[0]) + 3'(pe_rd_data[1]) +
                      3'(pe_rd_data[2]) + 3'(pe_rd_data[3]);

    assign busy      = (state == READ) || (state == DRAIN);
    assign pack_done = (state == DONE);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ: begin
                if (!pack_start)                state_nxt = IDLE;
                else if (pe_rd_addr == LAST_ADDR) state_nxt = DRAIN;
            end
            // The last word's write strobe is the final event of the frame.
            DRAIN: begin
                if (!pack_start)   state_nxt = IDLE;
                else if (out_wr_en) state_nxt = DONE;
            end
            DONE:    if (!pack_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_rd_addr  <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            fg_count    <= '0;
            armed       <= 1'b1;
            rd_valid    <= 1'b0;
            nib_idx     <= '0;
            word_idx    <= '0;
            acc         <= '0;
        end else begin
            out_wr_en <= 1'b0;
            rd_valid  <= (state == READ) && pack_start;

            if (!pack_start) armed <= 1'b1;
            else if (start)  armed <= 1'b0;

            if (start) begin
                pe_rd_addr <= '0;
                fg_count   <= '0;
                acc        <= '0;
                nib_idx    <= '0;
                word_idx   <= '0;
            end else begin
                if ((state == READ) && pack_start && (pe_rd_addr != LAST_ADDR))
                    pe_rd_addr <= pe_rd_addr + 1'b1;

                if (capture) begin
                    fg_count <= fg_count + CNT_W'(nib_ones);
                    nib_idx  <= nib_idx + 1'b1;
                    // Eighth nibble completes the word; it goes straight to the write port.
                    if (nib_idx == 3'd7) begin
                        out_wr_en   <= 1'b1;
                        out_wr_addr <= word_idx;
                        out_wr_data <= {pe_rd_data, acc};
                        word_idx    <= word_idx + 1'b1;
                    end else begin
                        acc[{nib_idx, 2'b00} +: 4] <= pe_rd_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_pack_unit.sv
// Directed bench for pixel_pack_unit at NUM_PIXELS=64 (16 reads, 2 words per frame).
module tb_pixel_pack_unit;

    localparam int NP  = 64;
    localparam int RAW = 4;
    localparam int WAW = 1;

    logic             clk;
    logic             reset_n;
    logic             pack_start;
    logic [RAW-1:0]   pe_rd_addr;
    logic [3:0]       pe_rd_data;
    logic             out_wr_en;
    logic [WAW-1:0]   out_wr_addr;
    logic [31:0]      out_wr_data;
    logic [6:0]       fg_count;
    logic             pack_done;
    logic             busy;

    pixel_pack_unit #(
        .NUM_PIXELS (NP),
        .RD_ADDR_W  (RAW),
        .WR_ADDR_W  (WAW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pack_start  (pack_start),
        .pe_rd_addr  (pe_rd_addr),
        .pe_rd_data  (pe_rd_data),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .out_wr_data (out_wr_data),
        .fg_count    (fg_count),
        .pack_done   (pack_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the four PE result buffers: synchronous read, one nibble per address.
    logic [3:0] mem [16];
    always @(posedge clk) pe_rd_data <= mem[pe_rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] nib;
        logic [31:0] w0;
        logic [31:0] w1;
        int          fg;
    } vec_t;

    vec_t vecs [6];

    int          n_wr;
    int          done_cyc;
    int          wr_cyc  [2];
    logic [0:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic        busy0;
    logic [6:0]  fg_at0;
    logic [6:0]  fg_final;

    task automatic load_mem(input logic [63:0] nib);
        for (int k = 0; k < 16; k++) mem[k] = nib[4*k +: 4];
    endtask

    // Called at a falling edge; the next rising edge begins cycle 0 (READ).
    task automatic run_frame(input logic [63:0] nib);
        load_mem(nib);
        n_wr     = 0;
        done_cyc = -1;
        pack_start = 1'b1;
        for (int n = 0; n < 60 && done_cyc < 0; n++) begin
            @(negedge clk);
            if (n == 0) begin
                busy0  = busy;
                fg_at0 = fg_count;
            end
            if (out_wr_en) begin
                if (n_wr < 2) begin
                    wr_cyc[n_wr]  = n;
                    wr_addr[n_wr] = out_wr_addr;
                    wr_data[n_wr] = out_wr_data;
                end
                n_wr++;
            end
            if (pack_done) done_cyc = n;
        end
        fg_final = fg_count;
    endtask

    task automatic check_frame(input vec_t v);
        check({v.name, " busy@0"},     64'(busy0),      64'd1);
        check({v.name, " writes"},     64'(n_wr),       64'd2);
        check({v.name, " w0 cycle"},   64'(wr_cyc[0]),  64'd9);
        check({v.name, " w0 addr"},    64'(wr_addr[0]), 64'd0);
        check({v.name, " w0 data"},    64'(wr_data[0]), 64'(v.w0));
        check({v.name, " w1 cycle"},   64'(wr_cyc[1]),  64'd17);
        check({v.name, " w1 addr"},    64'(wr_addr[1]), 64'd1);
        check({v.name, " w1 data"},    64'(wr_data[1]), 64'(v.w1));
        check({v.name, " done cycle"}, 64'(done_cyc),   64'd18);
        check({v.name, " fg_count"},   64'(fg_final),   64'(v.fg));
    endtask

    task automatic hold_done(input vec_t v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({v.name, " hold done"}, 64'(pack_done), 64'd1);
            check({v.name, " hold fg"},   64'(fg_count),  64'(v.fg));
            check({v.name, " hold wr_en"}, 64'(out_wr_en), 64'd0);
        end
    endtask

    task automatic end_frame(input string name);
        pack_start = 1'b0;
        @(negedge clk);
        check({name, " done fell"}, 64'(pack_done), 64'd0);
        check({name, " idle busy"}, 64'(busy),      64'd0);
    endtask

    task automatic abort_at(input int k);
        int wr = 0;
        int dn = 0;
        load_mem(64'hFFFF_FFFF_FFFF_FFFF);
        pack_start = 1'b1;
        for (int n = 0; n <= k; n++) begin
            @(negedge clk);
            if (out_wr_en) wr++;
        end
        pack_start = 1'b0;
        @(negedge clk);
        check($sformatf("abort%0d busy", k),    64'(busy),       64'd0);
        check($sformatf("abort%0d addr", k),    64'(pe_rd_addr), 64'(k));
        if (out_wr_en) wr++;
        repeat (20) begin
            @(negedge clk);
            if (out_wr_en) wr++;
            if (pack_done) dn++;
        end
        check($sformatf("abort%0d writes", k), 64'(wr), 64'd0);
        check($sformatf("abort%0d done", k),   64'(dn), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64};
        vecs[1] = '{"lane0",    64'h1111_1111_1111_1111, 32'h1111_1111, 32'h1111_1111, 16};
        vecs[2] = '{"ramp",     64'hFEDC_BA98_7654_3210, 32'h7654_3210, 32'hFEDC_BA98, 32};
        vecs[3] = '{"zeros",    64'h0000_0000_0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[4] = '{"w0_edges", 64'h0000_0000_8000_0001, 32'h8000_0001, 32'h0000_0000, 2};
        vecs[5] = '{"pix_ends", 64'h8000_0000_0000_0001, 32'h0000_0001, 32'h8000_0000, 2};

        reset_n    = 1'b0;
        pack_start = 1'b0;
        load_mem('0);
        repeat (3) @(negedge clk);
        check("rst pe_rd_addr",  64'(pe_rd_addr),  64'd0);
        check("rst out_wr_en",   64'(out_wr_en),   64'd0);
        check("rst out_wr_addr", 64'(out_wr_addr), 64'd0);
        check("rst out_wr_data", 64'(out_wr_data), 64'd0);
        check("rst fg_count",    64'(fg_count),    64'd0);
        check("rst pack_done",   64'(pack_done),   64'd0);
        check("rst busy",        64'(busy),        64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].nib);
            check_frame(vecs[i]);
            hold_done(vecs[i], 2);
            end_frame(vecs[i].name);
        end

        // pack_start held through DONE, dropped one cycle, then raised for a second frame.
        run_frame(vecs[0].nib);
        check_frame(vecs[0]);
        hold_done(vecs[0], 3);
        pack_start = 1'b0;
        @(negedge clk);
        check("rearm done fell", 64'(pack_done), 64'd0);
        run_frame(vecs[2].nib);
        check("rearm fg cleared", 64'(fg_at0), 64'd0);
        check_frame(vecs[2]);
        end_frame("rearm");

        abort_at(5);
        abort_at(8);

        // Asynchronous reset in the middle of the second word.
        load_mem(64'hFFFF_FFFF_FFFF_FFFF);
        pack_start = 1'b1;
        for (int n = 0; n <= 12; n++) @(negedge clk);
        #1;
        reset_n    = 1'b0;
        pack_start = 1'b0;
        #1;
        check("mid rst pe_rd_addr",  64'(pe_rd_addr),  64'd0);
        check("mid rst out_wr_en",   64'(out_wr_en),   64'd0);
        check("mid rst out_wr_addr", 64'(out_wr_addr), 64'd0);
        check("mid rst out_wr_data", 64'(out_wr_data), 64'd0);
        check("mid rst fg_count",    64'(fg_count),    64'd0);
        check("mid rst pack_done",   64'(pack_done),   64'd0);
        check("mid rst busy",        64'(busy),        64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int wr = 0;
            int bz = 0;
            repeat (10) begin
                @(negedge clk);
                if (out_wr_en) wr++;
                if (busy || pack_done) bz++;
            end
            check("post rst writes", 64'(wr), 64'd0);
            check("post rst idle",   64'(bz), 64'd0);
        end
        run_frame(vecs[2].nib);
        check_frame(vecs[2]);
        end_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
